// File: rtl/mem_bus_pkg.sv
// Shared types for the memory responder: FSM states, latched request record
// and the byte-merge helper used by the write path.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_WAIT = 2'd1,
    MR_RESP = 2'd2
  } mr_state_t;

  localparam int MR_CNT_W = 4;
  // Full 30-bit word address of a 32-bit byte address; the RAM uses the low bits.
  localparam int MR_IDX_W = 30;

  typedef struct packed {
    logic [MR_IDX_W-1:0] idx;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
  } mem_req_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_stall_lfsr.sv
// Pseudo-random stall source: 16-bit Galois LFSR (taps 16,14,13,11) that
// requests a stall whenever its two low bits are zero.
module mem_stall_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rstn,
  output logic stall
);

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  always_comb begin
    lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign stall = (lfsr_reg[1:0] == 2'b00);

endmodule

// File: rtl/mem_responder.sv
// Memory end of the PROC_REQ/MEM_RDY/VALID handshake: word RAM with byte writes,
// one request in flight, fixed-latency VALID pulse. Random stalls under MEM_STALL_EN.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 32,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter string       INIT_FILE  = "",
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              PROC_REQ,
  output logic              MEM_RDY,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              WE,
  input  logic [3:0]        BE,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              VALID
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [MR_CNT_W-1:0] CNT_LOAD =
    (LATENCY > 1) ? MR_CNT_W'(LATENCY - 2) : '0;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "mem_responder: LATENCY must be in 1..15");
  end
  if (DATA_W != 32) begin : g_bad_width
    $fatal(1, "mem_responder: DATA_W must be 32");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  mr_state_t             state_reg, state_next;
  logic [MR_CNT_W-1:0]   cnt_reg, cnt_next;
  logic                  rdy_en_reg;
  logic [DATA_W-1:0]     rdata_reg;
  mem_req_t              req_reg, in_req, commit_req;
  logic                  stall, accept, commit;
  logic [DEPTH_LOG2-1:0] commit_idx;
  logic [31:0]           old_word, new_word;
  logic                  unused_bits;

`ifdef MEM_STALL_EN
  mem_stall_lfsr #(.SEED(LFSR_SEED)) u_stall (
    .clk   (CLK),
    .rstn  (RSTn),
    .stall (stall)
  );
  assign unused_bits = ^{ADDR[1:0], commit_req.idx[MR_IDX_W-1:DEPTH_LOG2]};
`else
  assign stall       = 1'b0;
  assign unused_bits = ^{ADDR[1:0], commit_req.idx[MR_IDX_W-1:DEPTH_LOG2], LFSR_SEED};
`endif

  // rdy_en_reg keeps MEM_RDY low for the cycle that follows a reset edge.
  assign MEM_RDY = rdy_en_reg && (state_reg != MR_WAIT) && !stall;
  assign accept  = PROC_REQ && MEM_RDY;
  assign VALID   = (state_reg == MR_RESP);
  assign RDATA   = rdata_reg;

  always_comb begin
    in_req.idx   = MR_IDX_W'(ADDR[ADDR_W-1:2]);
    in_req.we    = WE;
    in_req.be    = BE;
    in_req.wdata = WDATA;
  end

  // With LATENCY=1 the accept edge is also the commit edge, so the live inputs are used.
  assign commit_req = (LATENCY == 1) ? in_req : req_reg;
  assign commit_idx = commit_req.idx[DEPTH_LOG2-1:0];
  assign old_word   = mem[commit_idx];
  assign new_word   = commit_req.we ? merge_bytes(old_word, commit_req.wdata, commit_req.be)
                                    : old_word;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    case (state_reg)
      MR_IDLE, MR_RESP: begin
        state_next = MR_IDLE;
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = MR_RESP;
            commit     = 1'b1;
          end else begin
            state_next = MR_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      MR_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = MR_RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - MR_CNT_W'(1);
        end
      end
      default: state_next = MR_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_reg  <= MR_IDLE;
      cnt_reg    <= '0;
      rdy_en_reg <= 1'b0;
      rdata_reg  <= '0;
      req_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rdy_en_reg <= 1'b1;
      if (accept) begin
        req_reg <= in_req;
      end
      if (commit) begin
        rdata_reg <= new_word;
      end
    end
  end

  // RAM contents survive reset; a reset edge suppresses any pending commit.
  always_ff @(posedge CLK) begin
    if (RSTn && commit && commit_req.we) begin
      mem[commit_idx] <= new_word;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (default build, LATENCY=2): directed
// scenarios plus randomized requests checked against a behavioural memory model.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        PROC_REQ = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] ADDR = '0;
  logic [3:0]  BE = '0;
  logic [31:0] WDATA = '0;
  logic        MEM_RDY;
  logic [31:0] RDATA;
  logic        VALID;

  int total = 0;
  int passed = 0;

  logic [31:0] model_mem [0:1023];

  always #5 CLK = ~CLK;

  mem_responder #(.LATENCY(LAT)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .PROC_REQ (PROC_REQ),
    .MEM_RDY  (MEM_RDY),
    .ADDR     (ADDR),
    .WE       (WE),
    .BE       (BE),
    .WDATA    (WDATA),
    .RDATA    (RDATA),
    .VALID    (VALID)
  );

  function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] mask = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mask = mask | (32'hFF << (8 * i));
    end
    return (old_word & ~mask) | (wd & mask);
  endfunction

  // Model: word index wraps modulo 1024, byte offset ignored.
  task automatic model_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, output logic [31:0] expected);
    int idx;
    idx = int'((addr >> 2) % 32'd1024);
    if (we) model_mem[idx] = apply_be(model_mem[idx], wd, be);
    expected = model_mem[idx];
  endtask

  // Issue one request, then count cycles after the accept edge until VALID (-1 on timeout).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
    int waited;
    @(negedge CLK);
    WE = we; ADDR = addr; BE = be; WDATA = wd; PROC_REQ = 1'b1;
    waited = 0;
    while (MEM_RDY !== 1'b1 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    if (MEM_RDY !== 1'b1) begin
      PROC_REQ = 1'b0;
      rd = 'x;
      lat = -1;
      $display("txn we=%0d addr=%h never accepted", we, addr);
      return;
    end
    @(posedge CLK);
    #1;
    PROC_REQ = 1'b0; WE = 1'b0; ADDR = $urandom; WDATA = $urandom; BE = 4'($urandom);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (VALID !== 1'b1 && lat < 40);
    rd = RDATA;
    if (VALID !== 1'b1) lat = -1;
    $display("txn we=%0d addr=%h be=%b wdata=%h -> rdata=%h lat=%0d", we, addr, be, wd, rd, lat);
  endtask

  task automatic test_reset();
    RSTn = 1'b0; PROC_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++; if (VALID !== 1'b0) $display("FAIL reset_valid: got %b expected 0", VALID); else passed++;
    total++; if (RDATA !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", RDATA); else passed++;
    total++; if (MEM_RDY !== 1'b0) $display("FAIL reset_rdy_low: got %b expected 0", MEM_RDY); else passed++;
    RSTn = 1'b1;
    @(negedge CLK);
    total++; if (MEM_RDY !== 1'b1) $display("FAIL release_rdy: got %b expected 1", MEM_RDY); else passed++;
    total++; if (VALID !== 1'b0) $display("FAIL release_valid: got %b expected 0", VALID); else passed++;
  endtask

  task automatic test_read_latency();
    logic [31:0] rd, expected;
    int lat;
    do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
    model_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, expected);
    total++; if (lat !== LAT) $display("FAIL wr_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (rd !== expected) $display("FAIL wr_postdata: got %h expected %h", rd, expected); else passed++;
    do_req(1'b0, 32'h10, 4'h0, $urandom, rd, lat);
    model_req(1'b0, 32'h10, 4'h0, 32'h0, expected);
    total++; if (lat !== LAT) $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (rd !== expected) $display("FAIL rd_data: got %h expected %h", rd, expected); else passed++;
    do_req(1'b0, 32'h0005_3012, 4'hF, 32'h0, rd, lat);
    model_req(1'b0, 32'h0005_3012, 4'hF, 32'h0, expected);
    total++; if (rd !== expected) $display("FAIL rd_alias: got %h expected %h", rd, expected); else passed++;
  endtask

  task automatic test_write_merge();
    logic [31:0] rd, expected;
    int lat;
    do_req(1'b1, 32'h20, 4'hF, 32'hAAAAAAAA, rd, lat);
    model_req(1'b1, 32'h20, 4'hF, 32'hAAAAAAAA, expected);
    do_req(1'b1, 32'h20, 4'b0101, 32'h11223344, rd, lat);
    model_req(1'b1, 32'h20, 4'b0101, 32'h11223344, expected);
    total++; if (rd !== expected) $display("FAIL merge_postdata: got %h expected %h", rd, expected); else passed++;
    do_req(1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    model_req(1'b0, 32'h20, 4'hF, 32'h0, expected);
    total++; if (rd !== expected) $display("FAIL merge_readback: got %h expected %h", rd, expected); else passed++;
    do_req(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, rd, lat);
    model_req(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, expected);
    total++; if (lat !== LAT) $display("FAIL be0_valid: got lat %0d expected %0d", lat, LAT); else passed++;
    total++; if (rd !== expected) $display("FAIL be0_nochange: got %h expected %h", rd, expected); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, expected, wd;
    int lat, n_acc, nrdy_low;
    int valid_cyc[$];
    int acc_cyc[$];
    logic [31:0] valid_dat[$];
    logic acc;
    for (int i = 0; i < 3; i++) begin
      wd = $urandom;
      do_req(1'b1, 32'(4 * i), 4'hF, wd, rd, lat);
      model_req(1'b1, 32'(4 * i), 4'hF, wd, expected);
    end
    n_acc = 0; nrdy_low = 0;
    @(negedge CLK);
    ADDR = 32'h0; WE = 1'b0; BE = 4'hF; PROC_REQ = 1'b1;
    for (int cyc = 0; cyc < 40 && valid_cyc.size() < 3; cyc++) begin
      if (VALID === 1'b1) begin
        valid_cyc.push_back(cyc);
        valid_dat.push_back(RDATA);
      end
      acc = PROC_REQ && (MEM_RDY === 1'b1);
      if (acc) acc_cyc.push_back(cyc);
      else if (PROC_REQ) nrdy_low++;
      @(posedge CLK);
      #1;
      if (acc) begin
        n_acc++;
        ADDR = 32'(4 * n_acc);
        if (n_acc == 3) PROC_REQ = 1'b0;
      end
      @(negedge CLK);
    end
    PROC_REQ = 1'b0;
    $display("txn back-to-back: accepts=%0d pulses=%0d rdy_low=%0d", acc_cyc.size(), valid_cyc.size(), nrdy_low);
    total++; if (valid_cyc.size() !== 3) $display("FAIL b2b_pulses: got %0d expected 3", valid_cyc.size()); else passed++;
    total++; if (nrdy_low !== 2 * (LAT - 1)) $display("FAIL b2b_rdy_low: got %0d expected %0d", nrdy_low, 2 * (LAT - 1)); else passed++;
    if (valid_cyc.size() > 0 && acc_cyc.size() > 0) begin
      total++;
      if (valid_cyc[0] - acc_cyc[0] !== LAT) $display("FAIL b2b_first_lat: got %0d expected %0d", valid_cyc[0] - acc_cyc[0], LAT);
      else passed++;
    end
    for (int i = 1; i < valid_cyc.size(); i++) begin
      total++;
      if (valid_cyc[i] - valid_cyc[i-1] !== LAT) $display("FAIL b2b_gap%0d: got %0d expected %0d", i, valid_cyc[i] - valid_cyc[i-1], LAT);
      else passed++;
    end
    for (int i = 0; i < valid_dat.size(); i++) begin
      total++;
      if (valid_dat[i] !== model_mem[i]) $display("FAIL b2b_data%0d: got %h expected %h", i, valid_dat[i], model_mem[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd, expected;
    int lat, waited;
    logic seen_valid;
    do_req(1'b1, 32'h30, 4'hF, 32'h5A5A_0F0F, rd, lat);
    model_req(1'b1, 32'h30, 4'hF, 32'h5A5A_0F0F, expected);
    @(negedge CLK);
    WE = 1'b1; ADDR = 32'h30; BE = 4'hF; WDATA = 32'hA5A5_F0F0; PROC_REQ = 1'b1;
    waited = 0;
    while (MEM_RDY !== 1'b1 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    @(posedge CLK);
    @(negedge CLK);
    total++; if (MEM_RDY !== 1'b0) $display("FAIL wait_rdy_low: got %b expected 0", MEM_RDY); else passed++;
    RSTn = 1'b0; PROC_REQ = 1'b0; WE = 1'b0;
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (VALID !== 1'b0) seen_valid = 1'b1;
    end
    total++; if (seen_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", seen_valid); else passed++;
    RSTn = 1'b1;
    @(negedge CLK);
    do_req(1'b0, 32'h30, 4'hF, 32'h0, rd, lat);
    model_req(1'b0, 32'h30, 4'hF, 32'h0, expected);
    total++; if (rd !== expected) $display("FAIL rst_mid_nowrite: got %h expected %h", rd, expected); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] rd, expected, wd, addr;
    logic [3:0] be;
    logic we;
    int lat, idx;
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      do_req(1'b1, 32'(4 * i), 4'hF, wd, rd, lat);
      model_req(1'b1, 32'(4 * i), 4'hF, wd, expected);
    end
    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, 63);
      addr = ($urandom & ~32'h0000_0FFC) | 32'(idx << 2);
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      wd = $urandom;
      do_req(we, addr, be, wd, rd, lat);
      model_req(we, addr, be, wd, expected);
      total++; if (lat !== LAT) $display("FAIL rand_lat[%0d]: got %0d expected %0d", n, lat, LAT); else passed++;
      total++; if (rd !== expected) $display("FAIL rand_data[%0d]: got %h expected %h", n, rd, expected); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_merge();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d passed so far", passed, total);
    $fatal(1, "timeout");
  end

endmodule
